// File: rtl/error_event_logger.sv
// -----------------------------------------------------------------------------
// error_event_logger
//
// Sits downstream of the CPU error aggregator. It detects rising edges on the
// per-source error flags and treats each cycle with at least one new rising
// bit as a single event. For each event it:
//   - sets the sticky CPU error output,
//   - captures the first event's source mask and timestamp since reset/clear,
//   - pushes {mask, timestamp} into a small show-ahead event FIFO.
// A debug reader drains the FIFO over a valid/ready handshake.
//
// Ports
//   clk                system clock, rising edge
//   rst_n              synchronous reset, ACTIVE HIGH (1 = reset)
//   error_src_i        raw per-source error flags (level)
//   clear_i            software clear of logged state (FIFO, first_*, sticky)
//   cpu_inner_error_o  sticky: an event was captured since reset/clear
//   first_src_o        source mask of the first captured event
//   first_ts_o         timestamp of the first captured event
//   log_valid_o        FIFO non-empty, head entry presented
//   log_src_o          head entry source mask (don't-care when not valid)
//   log_ts_o           head entry timestamp (don't-care when not valid)
//   log_ready_i        reader accepts the head entry
//   log_count_o        FIFO occupancy
//   overflow_o         sticky: an event was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module error_event_logger #(
   parameter int SRC_W = 10,
   parameter int TS_W  = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [SRC_W-1:0]         error_src_i,
   input  logic                     clear_i,
   output logic                     cpu_inner_error_o,
   output logic [SRC_W-1:0]         first_src_o,
   output logic [TS_W-1:0]          first_ts_o,
   output logic                     log_valid_o,
   output logic [SRC_W-1:0]         log_src_o,
   output logic [TS_W-1:0]          log_ts_o,
   input  logic                     log_ready_i,
   output logic [$clog2(DEPTH):0]   log_count_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [TS_W-1:0]  ts_r;
   logic [SRC_W-1:0] src_d_r;
   logic             sticky_r;
   logic [SRC_W-1:0] first_src_r;
   logic [TS_W-1:0]  first_ts_r;
   logic             overflow_r;
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;

   logic [SRC_W-1:0] src_mem_r [DEPTH];
   logic [TS_W-1:0]  ts_mem_r  [DEPTH];

   logic [SRC_W-1:0] new_s;
   logic             event_s;
   logic             full_s;
   logic             empty_s;
   logic             pop_s;
   logic             push_s;
   logic             drop_s;

   // Edge detection and FIFO handshake decode; clear suppresses both push and
   // pop so that a clear cycle leaves the FIFO empty regardless of the reader.
   always_comb begin
      new_s   = {SRC_W{1'b0}};
      event_s = 1'b0;
      full_s  = 1'b0;
      empty_s = 1'b1;
      pop_s   = 1'b0;
      push_s  = 1'b0;
      drop_s  = 1'b0;

      new_s   = error_src_i & ~src_d_r;
      event_s = |new_s;
      full_s  = (count_r == CW'(DEPTH));
      empty_s = (count_r == {CW{1'b0}});
      pop_s   = ~empty_s & log_ready_i & ~clear_i;
      // A full FIFO still accepts the push when the head leaves this cycle.
      push_s  = event_s & ~clear_i & (~full_s | pop_s);
      drop_s  = event_s & ~clear_i & full_s & ~pop_s;
   end

   // Counter, previous-sample register, capture state and FIFO bookkeeping.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         ts_r        <= {TS_W{1'b0}};
         src_d_r     <= {SRC_W{1'b0}};
         sticky_r    <= 1'b0;
         first_src_r <= {SRC_W{1'b0}};
         first_ts_r  <= {TS_W{1'b0}};
         overflow_r  <= 1'b0;
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
      end else begin
         ts_r    <= ts_r + TS_W'(1);
         // Updated even on clear cycles, so an edge seen during clear is lost.
         src_d_r <= error_src_i;

         if (clear_i) begin
            sticky_r    <= 1'b0;
            first_src_r <= {SRC_W{1'b0}};
            first_ts_r  <= {TS_W{1'b0}};
            overflow_r  <= 1'b0;
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
         end else begin
            if (event_s) begin
               sticky_r <= 1'b1;
               // The sticky bit doubles as "first event already captured".
               if (!sticky_r) begin
                  first_src_r <= new_s;
                  first_ts_r  <= ts_r;
               end else begin
                  first_src_r <= first_src_r;
                  first_ts_r  <= first_ts_r;
               end
            end else begin
               sticky_r <= sticky_r;
            end

            if (drop_s) begin
               overflow_r <= 1'b1;
            end else begin
               overflow_r <= overflow_r;
            end

            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
               wr_ptr_r <= wr_ptr_r;
            end

            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
               rd_ptr_r <= rd_ptr_r;
            end

            if (push_s && !pop_s) begin
               count_r <= count_r + CW'(1);
            end else if (pop_s && !push_s) begin
               count_r <= count_r - CW'(1);
            end else begin
               count_r <= count_r;
            end
         end
      end
   end

   // Event storage; contents need no reset because validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push_s) begin
         src_mem_r[wr_ptr_r] <= new_s;
         ts_mem_r[wr_ptr_r]  <= ts_r;
      end else begin
         src_mem_r[wr_ptr_r] <= src_mem_r[wr_ptr_r];
         ts_mem_r[wr_ptr_r]  <= ts_mem_r[wr_ptr_r];
      end
   end

   assign cpu_inner_error_o = sticky_r;
   assign first_src_o       = first_src_r;
   assign first_ts_o        = first_ts_r;
   assign overflow_o        = overflow_r;
   assign log_count_o       = count_r;
   assign log_valid_o       = ~empty_s;
   assign log_src_o         = src_mem_r[rd_ptr_r];
   assign log_ts_o          = ts_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_error_event_logger.sv
// -----------------------------------------------------------------------------
// tb_error_event_logger
//
// Self-checking bench for error_event_logger. A behavioural model (event
// queue plus a few scalars) is advanced at every rising edge from the same
// inputs the DUT sees; all DUT outputs are compared against it on the falling
// edge. Directed scenarios cover the documented corner cases, followed by a
// randomized phase with varying reader back-pressure, clears and resets.
// -----------------------------------------------------------------------------
module tb_error_event_logger;

   localparam int SRC_W = 10;
   localparam int TS_W  = 32;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic [SRC_W-1:0] src;
      logic [TS_W-1:0]  ts;
   } ev_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [SRC_W-1:0] error_src_i = 10'h000;
   logic             clear_i = 1'b0;
   logic             log_ready_i = 1'b0;
   logic             cpu_inner_error_o;
   logic [SRC_W-1:0] first_src_o;
   logic [TS_W-1:0]  first_ts_o;
   logic             log_valid_o;
   logic [SRC_W-1:0] log_src_o;
   logic [TS_W-1:0]  log_ts_o;
   logic [3:0]       log_count_o;
   logic             overflow_o;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [TS_W-1:0]  m_ts;
   logic [SRC_W-1:0] m_prev;
   bit               m_err;
   logic [SRC_W-1:0] m_fsrc;
   logic [TS_W-1:0]  m_fts;
   bit               m_ovf;
   ev_t              m_q[$];

   error_event_logger #(.SRC_W(SRC_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .error_src_i       (error_src_i),
      .clear_i           (clear_i),
      .cpu_inner_error_o (cpu_inner_error_o),
      .first_src_o       (first_src_o),
      .first_ts_o        (first_ts_o),
      .log_valid_o       (log_valid_o),
      .log_src_o         (log_src_o),
      .log_ts_o          (log_ts_o),
      .log_ready_i       (log_ready_i),
      .log_count_o       (log_count_o),
      .overflow_o        (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the currently applied inputs.
   task automatic model_update();
      logic [SRC_W-1:0] nw;
      if (rst_n) begin
         m_ts = 32'd0; m_prev = 10'h000; m_err = 1'b0; m_fsrc = 10'h000;
         m_fts = 32'd0; m_ovf = 1'b0; m_q.delete();
      end else begin
         nw = error_src_i & ~m_prev;
         if (clear_i) begin
            m_err = 1'b0; m_fsrc = 10'h000; m_fts = 32'd0; m_ovf = 1'b0;
            m_q.delete();
         end else begin
            if (m_q.size() != 0 && log_ready_i) void'(m_q.pop_front());
            if (nw != 10'h000) begin
               if (!m_err) begin
                  m_fsrc = nw;
                  m_fts  = m_ts;
               end
               m_err = 1'b1;
               if (m_q.size() < DEPTH) m_q.push_back('{src: nw, ts: m_ts});
               else m_ovf = 1'b1;
            end
         end
         m_ts   = m_ts + 32'd1;
         m_prev = error_src_i;
      end
   endtask

   task automatic compare_all();
      check("sticky",    64'(cpu_inner_error_o), 64'(m_err));
      check("first_src", 64'(first_src_o), 64'(m_fsrc));
      check("first_ts",  64'(first_ts_o), 64'(m_fts));
      check("overflow",  64'(overflow_o), 64'(m_ovf));
      check("count",     64'(log_count_o), 64'(m_q.size()));
      check("valid",     64'(log_valid_o), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("head_src", 64'(log_src_o), 64'(m_q[0].src));
         check("head_ts",  64'(log_ts_o), 64'(m_q[0].ts));
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_update();
         @(negedge clk);
         compare_all();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      tick(1);
      rst_n = 1'b0;
   endtask

   initial begin
      int mode;
      // 1: single held source logs once, timestamp 5
      error_src_i = 10'h000; log_ready_i = 1'b0; clear_i = 1'b0;
      do_reset();
      check("rst_sticky", 64'(cpu_inner_error_o), 64'd0);
      check("rst_count",  64'(log_count_o), 64'd0);
      tick(5);
      error_src_i = 10'h040;
      tick(1);
      check("t1_sticky", 64'(cpu_inner_error_o), 64'd1);
      check("t1_fsrc",   64'(first_src_o), 64'h040);
      check("t1_fts",    64'(first_ts_o), 64'd5);
      check("t1_head",   64'(log_src_o), 64'h040);
      tick(10);
      check("t1_count",  64'(log_count_o), 64'd1);

      // 2: second event with an additional rising bit
      error_src_i = 10'h000;
      do_reset();
      tick(3);
      error_src_i = 10'h001;
      tick(4);
      error_src_i = 10'h201;
      tick(1);
      check("t2_count",  64'(log_count_o), 64'd2);
      check("t2_hsrc",   64'(log_src_o), 64'h001);
      check("t2_hts",    64'(log_ts_o), 64'd3);
      check("t2_fts",    64'(first_ts_o), 64'd3);
      log_ready_i = 1'b1;
      tick(1);
      log_ready_i = 1'b0;
      check("t2_hsrc2",  64'(log_src_o), 64'h200);
      check("t2_hts2",   64'(log_ts_o), 64'd7);

      // 3: nine events into an 8-deep FIFO
      error_src_i = 10'h000;
      clear_i = 1'b1; tick(1); clear_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         error_src_i = 10'h001 << i;
         tick(1);
      end
      check("t3_count", 64'(log_count_o), 64'd8);
      check("t3_ovf",   64'(overflow_o), 64'd1);
      check("t3_head",  64'(log_src_o), 64'h001);

      // 4: full FIFO with simultaneous push and pop
      error_src_i = 10'h000;
      clear_i = 1'b1; tick(1); clear_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         error_src_i = 10'h001 << i;
         tick(1);
      end
      error_src_i = 10'h100;
      log_ready_i = 1'b1;
      tick(1);
      check("t4_count", 64'(log_count_o), 64'd8);
      check("t4_ovf",   64'(overflow_o), 64'd0);
      tick(7);
      log_ready_i = 1'b0;
      check("t4_last",  64'(log_src_o), 64'h100);
      check("t4_cnt1",  64'(log_count_o), 64'd1);

      // 5: clear coinciding with a rising edge loses that edge
      error_src_i = 10'h000;
      tick(1);
      clear_i = 1'b1; error_src_i = 10'h010;
      tick(1);
      clear_i = 1'b0;
      check("t5_sticky", 64'(cpu_inner_error_o), 64'd0);
      check("t5_count",  64'(log_count_o), 64'd0);
      check("t5_fsrc",   64'(first_src_o), 64'h000);
      tick(3);
      check("t5_hold",   64'(log_count_o), 64'd0);
      error_src_i = 10'h000; tick(1);
      error_src_i = 10'h010; tick(1);
      check("t5_relog",  64'(log_src_o), 64'h010);
      check("t5_cnt",    64'(log_count_o), 64'd1);

      // 6: reset mid-drain with five entries
      for (int i = 0; i < 4; i++) begin
         error_src_i = 10'h001 << i;
         tick(1);
      end
      check("t6_cnt5", 64'(log_count_o), 64'd5);
      error_src_i = 10'h000;
      do_reset();
      check("t6_count", 64'(log_count_o), 64'd0);
      check("t6_valid", 64'(log_valid_o), 64'd0);
      check("t6_sticky", 64'(cpu_inner_error_o), 64'd0);
      tick(2);
      error_src_i = 10'h004;
      tick(1);
      check("t6_fts", 64'(first_ts_o), 64'd2);

      // randomized phase
      mode = 0;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) mode = $urandom_range(0, 3);
         if ($urandom_range(0, 2) == 0)
            error_src_i = error_src_i ^ (10'h001 << $urandom_range(0, 9));
         if ($urandom_range(0, 15) == 0)
            error_src_i = 10'($urandom);
         case (mode)
            0: log_ready_i = 1'b0;
            1: log_ready_i = ($urandom_range(0, 3) == 0);
            2: log_ready_i = ($urandom_range(0, 1) == 0);
            default: log_ready_i = ($urandom_range(0, 9) != 0);
         endcase
         clear_i = ($urandom_range(0, 149) == 0);
         rst_n   = ($urandom_range(0, 399) == 0);
         tick(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/error_event_logger.md
Name: error_event_logger

Overview:
- Sits directly downstream of the CPU error aggregator and consumes the same per-source error flags, one bit per source.
- The aggregator only keeps a single sticky bit. This block adds rising-edge detection, first-error capture with source mask and timestamp, and a small event FIFO.
- The FIFO is drained by a debug reader over a valid/ready handshake. The block also drives the sticky CPU error output.

Parameters:
- SRC_W, 10, number of error sources. Bit order: [0] inst_cache, [1] data_cache, [2] if, [3] ift, [4] id, [5] launch, [6] ex, [7] mm, [8] mem, [9] wb.
- TS_W, 32, timestamp / free-running cycle counter width.
- DEPTH, 8, event FIFO depth; power of two, ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-high reset (1 = reset asserted).
- error_src_i  input  SRC_W  raw per-source error flags, level.
- clear_i  input  1  software clear of the logged error state.
- cpu_inner_error_o  output  1  sticky error; 1 once any event is captured.
- first_src_o  output  SRC_W  source mask of the first captured event.
- first_ts_o  output  TS_W  timestamp of the first captured event.
- log_valid_o  output  1  FIFO non-empty; head entry presented.
- log_src_o  output  SRC_W  head entry source mask.
- log_ts_o  output  TS_W  head entry timestamp.
- log_ready_i  input  1  reader accepts the head entry.
- log_count_o  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow_o  output  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n=1 at an edge): all of the following are 0 after that edge.
  - cycle counter, src_d (previous sample), FIFO pointers and count
  - cpu_inner_error_o, first_src_o, first_ts_o, overflow_o, log_valid_o
- log_src_o/log_ts_o are don't-care while log_valid_o=0.
- Cycle counter ts:
  - Increments by 1 every non-reset cycle; wraps modulo 2^TS_W with no flag.
  - Unaffected by clear_i.
- Edge detection:
  - new = error_src_i & ~src_d, combinational. An event occurs when new != 0.
  - src_d <= error_src_i every non-reset cycle, including clear cycles.
  - A source held high therefore logs exactly once. It must drop and rise again to log again.
- Event timestamp: the ts value before increment in the cycle the event is detected.
- Event latency: every event effect below is visible in the outputs one cycle after the error_src_i edge is sampled.
  - cpu_inner_error_o <= 1.
  - If no event has been captured since reset/clear: first_src_o <= new, first_ts_o <= ts. Otherwise these hold.
  - Push {new, ts} into the FIFO, with the exceptions below.
- FIFO:
  - Show-ahead; log_valid_o = (count != 0).
  - Pop when log_valid_o & log_ready_i.
  - Full and no pop: the event is dropped, overflow_o <= 1, and first-capture/sticky still update.
  - Full with a simultaneous pop: the push is accepted and count is unchanged.
  - Empty: the push is visible at the head on the next cycle. There is no same-cycle bypass.
  - Pointers wrap modulo DEPTH.
- clear_i priority:
  - clear_i=1 at an edge zeroes cpu_inner_error_o, first_*, overflow_o, FIFO pointers and count.
  - An event in the same cycle is discarded; its edge is lost because src_d still updates.
  - A pop in the same cycle is irrelevant.
- Reset has priority over clear_i and events. Reset mid-drain discards all FIFO contents.
- Several bits rising in one cycle form a single event whose mask has multiple bits set.

Test Plan:
1. Reset, then error_src_i=0x040 at cycle ts=5 and held for 10 cycles.
   - Next cycle: cpu_inner_error_o=1, first_src_o=0x040, first_ts_o=5, log_valid_o=1, log_src_o=0x040, log_count_o=1.
   - No further entries appear.
2. Rises 0x001 at ts=3, then 0x201 (bit 9 newly rising) at ts=7, log_ready_i=0.
   - count=2; head {0x001,3}; first stays {0x001,3}.
   - After one ready cycle the head is {0x200,7}.
3. Generate 9 distinct rising events with log_ready_i=0 (DEPTH=8).
   - count=8, overflow_o=1, the ninth event is absent, and the head is the first event.
4. FIFO full, a new event with log_ready_i=1 in the same cycle.
   - count stays 8, overflow_o stays 0, and the new event becomes the last entry.
5. clear_i=1 in the same cycle as rising 0x010.
   - Next cycle: cpu_inner_error_o=0, count=0, first_src_o=0, overflow_o=0.
   - Holding 0x010 high produces no event.
   - Dropping it and re-raising it logs 0x010.
6. rst_n=1 while count=5.
   - Next cycle: all outputs 0 and the counter restarts from 0.
